// File: rtl/uart_freq_rx.sv
// uart_freq_rx: UART 8N1 receiver plus frame parser for blink-frequency commands.
// A frame is SYNC_BYTE, four data bytes (MSB first), then the XOR of the four
// data bytes. A frame that passes its checksum and carries a nonzero value
// replaces freq_o. Rejected frames, bad stop bits and inter-byte timeouts
// pulse frame_err_o and leave freq_o untouched.
module uart_freq_rx #(
  parameter int unsigned CLKS_PER_BIT = 217,
  parameter logic [31:0] DEFAULT_FREQ = 32'd2500000,
  parameter logic [31:0] TIMEOUT_CLKS = 32'd250000,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        CLK_25MHZ,
  input  logic        RSTN,
  input  logic        uart_rx_i,
  output logic [31:0] freq_o,
  output logic        freq_upd_o,
  output logic        frame_err_o,
  output logic        busy_o
);

  // Last count value of a full bit period and of a half bit period.
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [1:0] {
    P_SYNC,
    P_DATA,
    P_CHK
  } p_state_t;

  // Input synchronizer
  logic        rx_meta_q;
  logic        rx_sync_q;

  // Bit-level receiver
  rx_state_t   rx_state_q, rx_state_d;
  logic [15:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        wait_high_q, wait_high_d;
  logic        byte_valid;
  logic        stop_err;

  // Frame parser
  p_state_t    p_state_q, p_state_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [31:0] acc_q, acc_d;
  logic [7:0]  chk_q, chk_d;
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic [31:0] freq_q, freq_d;
  logic        freq_upd_q, freq_upd_d;
  logic        frame_err_q, frame_err_d;

  // Two-flop synchronizer for the asynchronous RX pin, idling high.
  always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
    if (RSTN) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx_i;
      rx_sync_q <= rx_meta_q;
    end
  end

  // Receiver next state: start-bit qualification at mid-bit, then mid-bit
  // sampling of data and stop; a low stop bit blocks new starts until the
  // line has been seen high again, so a held-low break decodes nothing.
  always_comb begin
    rx_state_d  = rx_state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    wait_high_d = wait_high_q;
    byte_valid  = 1'b0;
    stop_err    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        clk_cnt_d = 16'd0;
        bit_idx_d = 3'd0;
        if (wait_high_q) begin
          if (rx_sync_q) begin
            wait_high_d = 1'b0;
          end
        end else if (!rx_sync_q) begin
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
          if (!rx_sync_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      RX_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_sync_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            rx_state_d = RX_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      RX_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d  = 16'd0;
          rx_state_d = RX_IDLE;
          if (rx_sync_q) begin
            byte_valid = 1'b1;
          end else begin
            stop_err    = 1'b1;
            wait_high_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 16'd1;
        end
      end
      default: begin
        rx_state_d = RX_IDLE;
      end
    endcase
  end

  // Parser next state: hunt for the sync byte, gather four data bytes, then
  // judge the checksum byte. A received byte always beats the timeout.
  always_comb begin
    p_state_d   = p_state_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    chk_d       = chk_q;
    tmo_cnt_d   = tmo_cnt_q;
    freq_d      = freq_q;
    freq_upd_d  = 1'b0;
    frame_err_d = 1'b0;
    if (byte_valid) begin
      tmo_cnt_d = 32'd0;
      case (p_state_q)
        P_SYNC: begin
          if (shift_q == SYNC_BYTE) begin
            p_state_d  = P_DATA;
            byte_idx_d = 2'd0;
            chk_d      = 8'd0;
            acc_d      = 32'd0;
          end
        end
        P_DATA: begin
          acc_d      = {acc_q[23:0], shift_q};
          chk_d      = chk_q ^ shift_q;
          byte_idx_d = byte_idx_q + 2'd1;
          if (byte_idx_q == 2'd3) begin
            p_state_d = P_CHK;
          end
        end
        P_CHK: begin
          p_state_d = P_SYNC;
          if ((shift_q == chk_q) && (acc_q != 32'd0)) begin
            freq_d     = acc_q;
            freq_upd_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: begin
          p_state_d = P_SYNC;
        end
      endcase
    end else if (stop_err) begin
      p_state_d   = P_SYNC;
      tmo_cnt_d   = 32'd0;
      frame_err_d = 1'b1;
    end else if (p_state_q != P_SYNC) begin
      if (tmo_cnt_q == (TIMEOUT_CLKS - 32'd1)) begin
        p_state_d   = P_SYNC;
        tmo_cnt_d   = 32'd0;
        frame_err_d = 1'b1;
      end else begin
        tmo_cnt_d = tmo_cnt_q + 32'd1;
      end
    end else begin
      tmo_cnt_d = 32'd0;
    end
  end

  // State and output registers for the receiver and the parser.
  always_ff @(posedge CLK_25MHZ or posedge RSTN) begin
    if (RSTN) begin
      rx_state_q  <= RX_IDLE;
      clk_cnt_q   <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'd0;
      wait_high_q <= 1'b0;
      p_state_q   <= P_SYNC;
      byte_idx_q  <= 2'd0;
      acc_q       <= 32'd0;
      chk_q       <= 8'd0;
      tmo_cnt_q   <= 32'd0;
      freq_q      <= DEFAULT_FREQ;
      freq_upd_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_state_q  <= rx_state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wait_high_q <= wait_high_d;
      p_state_q   <= p_state_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      chk_q       <= chk_d;
      tmo_cnt_q   <= tmo_cnt_d;
      freq_q      <= freq_d;
      freq_upd_q  <= freq_upd_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign freq_o      = freq_q;
  assign freq_upd_o  = freq_upd_q;
  assign frame_err_o = frame_err_q;
  assign busy_o      = (p_state_q != P_SYNC);

endmodule

// File: tb/tb_uart_freq_rx.sv
// tb_uart_freq_rx: directed and randomized frames for uart_freq_rx, checked
// against a frame-level model. Bit period and timeout are shortened so the
// whole run stays short; the design logic is identical at any setting.
`timescale 1ns/1ps
module tb_uart_freq_rx;

  localparam int          CPB  = 40;
  localparam int          TMO  = 3000;
  localparam logic [31:0] DEF  = 32'd2500000;
  localparam logic [7:0]  SYNC = 8'hA5;

  logic        clk;
  logic        rstn;
  logic        rx;
  logic [31:0] freq;
  logic        upd;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // Pulse bookkeeping gathered by the monitor.
  int          upd_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  int          stray_cnt = 0;
  logic [31:0] prev_freq = DEF;

  // Expected state from the frame-level model.
  logic [31:0] exp_freq;
  int          exp_upd;
  int          exp_err;

  uart_freq_rx #(
    .CLKS_PER_BIT(CPB),
    .DEFAULT_FREQ(DEF),
    .TIMEOUT_CLKS(32'(TMO)),
    .SYNC_BYTE(SYNC)
  ) dut (
    .CLK_25MHZ(clk),
    .RSTN(rstn),
    .uart_rx_i(rx),
    .freq_o(freq),
    .freq_upd_o(upd),
    .frame_err_o(err),
    .busy_o(busy)
  );

  // 25 MHz clock.
  initial clk = 1'b0;
  always #20 clk = ~clk;

  // Count pulse cycles away from the active edge and flag freq changes
  // that are not accompanied by an update pulse.
  always @(negedge clk) begin
    if (!rstn) begin
      upd_cnt <= upd_cnt + int'(upd);
      err_cnt <= err_cnt + int'(err);
      if (upd && err) both_cnt <= both_cnt + 1;
      if ((freq !== prev_freq) && !upd) stray_cnt <= stray_cnt + 1;
    end
    prev_freq <= freq;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic holdLine(input logic val, input int cycles);
    rx = val;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Serialize one 8N1 byte, LSB first, with a chosen stop-bit level.
  task automatic applyStimulus(input logic [7:0] b, input logic stop_bit);
    holdLine(1'b0, CPB);
    for (int i = 0; i < 8; i++) holdLine(b[i], CPB);
    holdLine(stop_bit, CPB);
  endtask

  task automatic sendFrame(input logic [7:0] d0, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [7:0] d3,
                           input logic [7:0] c);
    applyStimulus(SYNC, 1'b1);
    applyStimulus(d0, 1'b1);
    applyStimulus(d1, 1'b1);
    applyStimulus(d2, 1'b1);
    applyStimulus(d3, 1'b1);
    applyStimulus(c, 1'b1);
  endtask

  // Frame rule: accepted when the checksum equals the XOR of the data bytes
  // and the big-endian value is nonzero.
  task automatic modelFrame(input logic [7:0] d0, input logic [7:0] d1,
                            input logic [7:0] d2, input logic [7:0] d3,
                            input logic [7:0] c);
    int unsigned value;
    value = int'(d0) * 16777216 + int'(d1) * 65536 + int'(d2) * 256 + int'(d3);
    if (((d0 ^ d1 ^ d2 ^ d3) == c) && (value != 0)) begin
      exp_freq = value;
      exp_upd++;
    end else begin
      exp_err++;
    end
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_freq"}, freq, exp_freq);
    checkOutput({tag, "_upd"}, 32'(upd_cnt), 32'(exp_upd));
    checkOutput({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  initial begin
    logic [7:0] d[4];
    logic [7:0] c;
    logic [7:0] g;
    int         mode;
    int         elapsed;
    int         base_err;

    exp_freq = DEF;
    exp_upd  = 0;
    exp_err  = 0;
    rstn     = 1'b1;
    rx       = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;

    // Idle after reset: default frequency, no pulses, not busy.
    holdLine(1'b1, 600);
    checkState("reset_idle");
    checkOutput("reset_busy", 32'(busy), 32'd0);

    // Directed frame 10000000.
    sendFrame(8'h00, 8'h98, 8'h96, 8'h80, 8'h8E);
    modelFrame(8'h00, 8'h98, 8'h96, 8'h80, 8'h8E);
    checkOutput("frame1_const", freq, 32'h00989680);
    checkState("frame1");

    // Same frame, wrong checksum.
    sendFrame(8'h00, 8'h98, 8'h96, 8'h80, 8'h8F);
    modelFrame(8'h00, 8'h98, 8'h96, 8'h80, 8'h8F);
    checkState("bad_chk");

    // Back to 2500000 with the matching checksum.
    c = 8'h00 ^ 8'h26 ^ 8'h25 ^ 8'hA0;
    sendFrame(8'h00, 8'h26, 8'h25, 8'hA0, c);
    modelFrame(8'h00, 8'h26, 8'h25, 8'hA0, c);
    checkOutput("frame_default_const", freq, DEF);
    checkState("frame_default");

    // Low stop bit on the third byte, then a long break.
    applyStimulus(SYNC, 1'b1);
    applyStimulus(8'h01, 1'b1);
    applyStimulus(8'h02, 1'b0);
    holdLine(1'b0, 30 * CPB);
    exp_err++;
    checkState("break");
    checkOutput("break_busy", 32'(busy), 32'd0);
    holdLine(1'b1, 2 * CPB);
    checkState("break_release");
    sendFrame(8'h00, 8'h01, 8'h02, 8'h03, 8'h00);
    modelFrame(8'h00, 8'h01, 8'h02, 8'h03, 8'h00);
    checkState("after_break");

    // Inter-byte timeout.
    applyStimulus(SYNC, 1'b1);
    applyStimulus(8'h12, 1'b1);
    checkOutput("tmo_busy_before", 32'(busy), 32'd1);
    base_err = err_cnt;
    elapsed  = 0;
    while ((err_cnt == base_err) && (elapsed < TMO + 4 * CPB)) begin
      @(posedge clk);
      #1;
      elapsed++;
    end
    exp_err++;
    checkOutput("tmo_window", 32'((elapsed >= TMO - CPB) && (elapsed <= TMO)), 32'd1);
    checkOutput("tmo_busy_after", 32'(busy), 32'd0);
    checkState("timeout");
    sendFrame(8'h01, 8'h00, 8'h00, 8'h00, 8'h01);
    modelFrame(8'h01, 8'h00, 8'h00, 8'h00, 8'h01);
    checkState("after_timeout");

    // Randomized frames, sometimes preceded by a non-sync byte, with random
    // gaps including zero.
    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(3) == 0) begin
        do g = 8'($urandom); while (g == SYNC);
        applyStimulus(g, 1'b1);
      end
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      c    = d[0] ^ d[1] ^ d[2] ^ d[3];
      mode = int'($urandom_range(3));
      if (mode == 0) begin
        c = c ^ 8'($urandom_range(255, 1));
      end else if (mode == 1) begin
        d[0] = 8'h00; d[1] = 8'h00; d[2] = 8'h00; d[3] = 8'h00;
        c = 8'h00;
      end
      sendFrame(d[0], d[1], d[2], d[3], c);
      modelFrame(d[0], d[1], d[2], d[3], c);
      checkState("random");
      if ($urandom_range(2) != 0) holdLine(1'b1, int'($urandom_range(2, 1)) * CPB);
    end

    // Short glitch on an idle line decodes nothing.
    holdLine(1'b1, 3 * CPB);
    holdLine(1'b0, 3);
    holdLine(1'b1, 15 * CPB);
    checkState("glitch");
    checkOutput("glitch_busy", 32'(busy), 32'd0);

    // Reset during the second data byte of a frame.
    applyStimulus(SYNC, 1'b1);
    applyStimulus(8'h44, 1'b1);
    holdLine(1'b0, CPB);
    holdLine(1'b1, CPB);
    holdLine(1'b0, CPB);
    rstn = 1'b1;
    holdLine(1'b1, 5);
    checkOutput("in_reset_freq", freq, DEF);
    checkOutput("in_reset_busy", 32'(busy), 32'd0);
    checkOutput("in_reset_upd", 32'(upd), 32'd0);
    checkOutput("in_reset_err", 32'(err), 32'd0);
    rstn = 1'b0;
    exp_freq = DEF;
    holdLine(1'b1, 15 * CPB);
    checkState("after_reset");
    checkOutput("after_reset_busy", 32'(busy), 32'd0);
    sendFrame(8'h00, 8'h0F, 8'h42, 8'h40, 8'h0F ^ 8'h42 ^ 8'h40);
    modelFrame(8'h00, 8'h0F, 8'h42, 8'h40, 8'h0F ^ 8'h42 ^ 8'h40);
    checkState("after_reset_frame");

    holdLine(1'b1, 2 * CPB);
    checkOutput("upd_err_same_cycle", 32'(both_cnt), 32'd0);
    checkOutput("freq_change_without_upd", 32'(stray_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
